// File: rtl/priority_arbiter8.sv
// Eight-way request arbiter with registered one-hot grant, optional round-robin
// rotation and a hold limit that forcibly revokes long-held grants.
module priority_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter bit RR_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_id,
  output logic       grant_valid,
  output logic       timeout
);

  localparam int            CW        = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_reg, state_next;
  logic [7:0]    grant_reg, grant_next;
  logic [2:0]    grant_id_reg, grant_id_next;
  logic          timeout_reg, timeout_next;
  logic [CW-1:0] hold_cnt_reg, hold_cnt_next;
  logic [2:0]    last_id_reg, last_id_next;

  logic [2:0] search_base;
  logic [7:0] req_rot;
  logic [2:0] win_offset;
  logic [2:0] winner_id;

  // Rotate requests so the search always starts at offset 0; fixed priority
  // is simply a rotation by zero.
  assign search_base = RR_EN ? (last_id_reg + 3'd1) : 3'd0;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_rot
      assign req_rot[gi] = req[3'(gi) + search_base];
    end
  endgenerate

  always_comb begin
    win_offset = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (req_rot[k]) win_offset = 3'(k);
    end
  end

  assign winner_id = search_base + win_offset;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      grant_reg    <= 8'h00;
      grant_id_reg <= 3'd0;
      timeout_reg  <= 1'b0;
      hold_cnt_reg <= '0;
      last_id_reg  <= 3'd7;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      grant_id_reg <= grant_id_next;
      timeout_reg  <= timeout_next;
      hold_cnt_reg <= hold_cnt_next;
      last_id_reg  <= last_id_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    grant_id_next = grant_id_reg;
    timeout_next  = 1'b0;
    hold_cnt_next = hold_cnt_reg;
    last_id_next  = last_id_reg;

    case (state_reg)
      IDLE: begin
        if (|req) begin
          state_next    = GRANT;
          grant_next    = 8'd1 << winner_id;
          grant_id_next = winner_id;
          hold_cnt_next = '0;
          last_id_next  = winner_id;
        end
      end
      GRANT: begin
        // A holder releasing on its final cycle wins over the timeout.
        if (!req[grant_id_reg]) begin
          state_next    = IDLE;
          grant_next    = 8'h00;
          grant_id_next = 3'd0;
          hold_cnt_next = '0;
        end else if (hold_cnt_reg == HOLD_LAST) begin
          state_next    = IDLE;
          grant_next    = 8'h00;
          grant_id_next = 3'd0;
          hold_cnt_next = '0;
          timeout_next  = 1'b1;
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next    = IDLE;
        grant_next    = 8'h00;
        grant_id_next = 3'd0;
        hold_cnt_next = '0;
      end
    endcase
  end

  assign grant       = grant_reg;
  assign grant_id    = grant_id_reg;
  assign grant_valid = |grant_reg;
  assign timeout     = timeout_reg;

endmodule

// File: tb/tb_priority_arbiter8.sv
// Runs a round-robin and a fixed-priority arbiter side by side on shared
// requests, comparing both against a cycle-count reference model.
module tb_priority_arbiter8;

  localparam int MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;

  logic [7:0] grant_rr, grant_fp;
  logic [2:0] grant_id_rr, grant_id_fp;
  logic       grant_valid_rr, grant_valid_fp;
  logic       timeout_rr, timeout_fp;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state per arbiter (0 = round-robin, 1 = fixed priority)
  int m_holder [2];
  int m_held   [2];
  int m_last   [2];
  int m_to     [2];

  always #5 clk = ~clk;

  priority_arbiter8 #(.MAX_HOLD(MAX_HOLD), .RR_EN(1'b1)) dut_rr (
    .clk(clk), .rst(rst), .req(req),
    .grant(grant_rr), .grant_id(grant_id_rr),
    .grant_valid(grant_valid_rr), .timeout(timeout_rr)
  );

  priority_arbiter8 #(.MAX_HOLD(MAX_HOLD), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst), .req(req),
    .grant(grant_fp), .grant_id(grant_id_fp),
    .grant_valid(grant_valid_fp), .timeout(timeout_fp)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_holder[d] = -1;
      m_held[d]   = 0;
      m_last[d]   = 7;
      m_to[d]     = 0;
    end
  endtask

  // First requester found scanning upward; round-robin starts after last winner.
  function automatic int pick(input logic [7:0] r, input int last, input bit rr);
    int start;
    int idx;
    start = rr ? (last + 1) % 8 : 0;
    for (int k = 0; k < 8; k++) begin
      idx = (start + k) % 8;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic [7:0] r);
    for (int d = 0; d < 2; d++) begin
      m_to[d] = 0;
      if (m_holder[d] < 0) begin
        if (r != 8'h00) begin
          m_holder[d] = pick(r, m_last[d], d == 0);
          m_held[d]   = 1;
          m_last[d]   = m_holder[d];
        end
      end else if (!r[m_holder[d]]) begin
        m_holder[d] = -1;
      end else if (m_held[d] == MAX_HOLD) begin
        m_holder[d] = -1;
        m_to[d]     = 1;
      end else begin
        m_held[d]++;
      end
    end
  endtask

  task automatic check_dut(input int d, input logic [7:0] g, input logic [2:0] id,
                           input logic v, input logic to);
    string pfx;
    int exp_g;
    int exp_id;
    int enc;
    pfx    = (d == 0) ? "rr" : "fp";
    exp_g  = (m_holder[d] < 0) ? 0 : (1 << m_holder[d]);
    exp_id = (m_holder[d] < 0) ? 0 : m_holder[d];
    check({pfx, "_grant"},    int'(g),  exp_g);
    check({pfx, "_grant_id"}, int'(id), exp_id);
    check({pfx, "_valid"},    int'(v),  (exp_g != 0) ? 1 : 0);
    check({pfx, "_timeout"},  int'(to), m_to[d]);
    // Structural invariants on the observed outputs themselves
    enc = 0;
    for (int i = 0; i < 8; i++) if (g[i]) enc = i;
    check({pfx, "_onehot0"},  ($countones(g) <= 1) ? 1 : 0, 1);
    check({pfx, "_id_enc"},   int'(id), enc);
    check({pfx, "_valid_or"}, int'(v),  int'(|g));
  endtask

  task automatic check_all();
    check_dut(0, grant_rr, grant_id_rr, grant_valid_rr, timeout_rr);
    check_dut(1, grant_fp, grant_id_fp, grant_valid_fp, timeout_fp);
  endtask

  // Drive at the falling edge, update the model at the rising edge, sample 1ns later.
  task automatic step(input logic [7:0] r);
    @(negedge clk);
    req = r;
    @(posedge clk);
    model_edge(r);
    #1;
    check_all();
  endtask

  task automatic steps(input logic [7:0] r, input int n);
    for (int i = 0; i < n; i++) step(r);
  endtask

  // Reset asserted between edges must clear outputs without a clock edge.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    req = 8'h00;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(8'h00);

    // Fixed priority pattern, held across several timeouts
    steps(8'b1010_0100, 40);
    steps(8'h00, 2);

    // Round-robin fairness sweep
    async_reset();
    steps(8'hFF, 9 * (MAX_HOLD + 1) + 2);
    steps(8'h00, 2);

    // Release after 5 grant cycles, then a full hold to confirm the count restarted
    async_reset();
    steps(8'h08, 6);
    step(8'h00);
    steps(8'h08, MAX_HOLD + 3);
    step(8'h00);

    // Wrap-around after last grant id 6
    async_reset();
    steps(8'h40, 3);
    step(8'h00);
    steps(8'h03, 2 * (MAX_HOLD + 1) + 2);
    step(8'h00);

    // Holder drops on its final cycle: no timeout
    async_reset();
    steps(8'h01, MAX_HOLD);
    step(8'h00);
    step(8'h00);

    // Reset mid-grant, then requester 7 must win first after reset
    steps(8'h05, 4);
    async_reset();
    steps(8'h80, 3);
    check("post_reset_id7", int'(grant_id_rr), 7);
    step(8'h00);

    // Randomised traffic: requests mostly held, occasionally changed
    begin
      logic [7:0] r;
      r = 8'h00;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 9) == 0) begin
          case ($urandom_range(0, 3))
            0:       r = 8'h00;
            1:       r = 8'(1 << $urandom_range(0, 7));
            default: r = 8'($urandom);
          endcase
        end
        step(r);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
